shift_wb_stage: RTL
===================

# shift_wb_stage

Registered writeback stage directly downstream of the combinational barrel shifter. It captures the shifter result and its N/Z/C/V flags behind a valid/ready handshake and buffers them in a 2-entry FIFO. It drains them toward the register-file write port and maintains the architectural NZCV status register. Its registered in_ready breaks the combinational path from register-file backpressure into the shifter.

## Interface
Parameters:
- WIDTH, 16, data width; must equal the shifter's WIDTH.
- DEST_W, 4, destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  shifter result valid.
- in_ready  out  1  stage can accept; depends only on internal registers.
- in_y  in  WIDTH  shifter result.
- in_negative, in_zero, in_cout, in_overflow  in  1 each  shifter flags.
- in_dest  in  DEST_W  destination register index.
- in_set_flags  in  1  instruction updates NZCV.
- out_valid  out  1  head entry valid.
- out_ready  in  1  register file accepts head entry.
- out_data  out  WIDTH  head entry result.
- out_dest  out  DEST_W  head entry destination.
- flags  out  4  status register {N,Z,C,V}.
- flag_clr  in  1  synchronous clear of flags.

## Operation
- Push: in_valid & in_ready. Pop: out_valid & out_ready.
- Storage is a 2-entry FIFO with a 2-bit count (0..2), a 1-bit write pointer and a 1-bit read pointer. Pointers wrap 1→0.
- in_ready = (count != 2). out_valid = (count != 0). out_data and out_dest always reflect the head entry and are don't-care when count = 0.
- Each entry stores in_y and in_dest only. Flags are not queued.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - Push while full cannot occur because in_ready = 0.
  - A pop while count = 0 is ignored, since out_valid = 0.
- Flag register, applied in this order within a cycle:
  - If flag_clr, flags ← 0.
  - Then, if push & in_set_flags, flags ← {in_negative, in_zero, in_cout, in_overflow}.
  - So an update wins over a simultaneous clear.
- Flags update at acceptance, not at drain. This gives in-order flag semantics without waiting on the register file.
- Reset asynchronously clears count, both pointers and flags. Reset mid-operation discards all buffered entries.

## Timing
- Reset values: in_ready = 1, out_valid = 0, flags = 4'b0000. out_data/out_dest are don't-care (storage need not be reset).
- Latency: a pushed entry appears on out_valid the cycle after acceptance when the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: 1 entry/cycle sustained when out_ready is held high.
- flags reflects an accepted instruction the cycle after its push.
- Paths: no combinational path from out_ready to in_ready, or from in_* to out_*.

## Configuration
- STICKY_OVERFLOW_EN
  - Defined: V becomes sticky. On push & in_set_flags, V ← V | in_overflow. Only flag_clr or reset clears it. With simultaneous flag_clr and update, V ← in_overflow.
  - Undefined: V loads in_overflow like N, Z and C.

## Test plan
- Reset: assert rst mid-stream with count = 2 → next cycle out_valid = 0, in_ready = 1, flags = 0000.
- Single op: push y = 16'h8000, dest = 3, set_flags = 1, N = 1, Z = 0, C = 0, V = 1.
  - Next cycle: out_valid = 1, out_data = 8000, out_dest = 3, flags = 1001.
  - Pop that cycle → out_valid = 0.
- Backpressure: hold out_ready = 0 and push A = 0001, B = 0002 → in_ready = 0 after the second push. Release out_ready → pops yield A then B in order, and in_ready returns to 1 the cycle after the first pop.
- Streaming: out_ready = 1 and in_valid = 1 for 8 cycles with y = 0..7 → outputs 0..7 on consecutive cycles, count never exceeds 1.
- Flag priority: flags = 1111, then in one cycle flag_clr = 1 with push (set_flags = 1, flags in = 0100) → flags = 0100. A push with set_flags = 0 then leaves flags = 0100.
- Sticky (only with STICKY_OVERFLOW_EN): push V = 1, then push V = 0 (both set_flags = 1) → V stays 1. After flag_clr → V = 0. Without the macro, V = 0 after the second push.

Source files
------------

// File: rtl/shift_wb_stage.sv
// shift_wb_stage
//   Registered writeback stage behind the barrel shifter. Accepts shifter
//   results through a valid/ready handshake into a 2-entry FIFO, drains them
//   toward the register-file write port, and keeps the NZCV status register.
//   in_ready is a function of the occupancy register only. That breaks the
//   combinational path from register-file backpressure back into the shifter.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         shifter result handshake
//   in_y, in_dest             result data and destination register index
//   in_negative/zero/cout/overflow, in_set_flags
//                             shifter flags and the flag-update enable
//   out_valid/out_ready       register-file handshake on the head entry
//   out_data, out_dest        head entry contents (don't-care when empty)
//   flags                     status register {N,Z,C,V}
//   flag_clr                  synchronous clear of flags
//
// Build option
//   STICKY_OVERFLOW_EN        when defined, V accumulates (OR) across updates
//                             and only flag_clr or reset clears it.
module shift_wb_stage #(
  parameter int WIDTH  = 16,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_y,
  input  logic              in_negative,
  input  logic              in_zero,
  input  logic              in_cout,
  input  logic              in_overflow,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_set_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [3:0]        flags,
  input  logic              flag_clr
);

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [DEST_W-1:0] dest;
  } wb_entry_t;

  wb_entry_t  mem [2];
  logic [1:0] count;
  logic       wr_ptr, rd_ptr;
  logic       push, pop;
  logic [3:0] flags_nxt;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data  = mem[rd_ptr].data;
  assign out_dest  = mem[rd_ptr].dest;

  // Storage carries no reset: the contents are only visible when count != 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: in_y, dest: in_dest};
  end

  // The clear is applied first and the update second, so an update wins
  // over a clear in the same cycle. With sticky V, the OR term reads the
  // cleared value, so clear+update yields V = in_overflow.
  always_comb begin
    flags_nxt = flag_clr ? 4'b0000 : flags;
    if (push && in_set_flags) begin
      flags_nxt[3:1] = {in_negative, in_zero, in_cout};
`ifdef STICKY_OVERFLOW_EN
      flags_nxt[0]   = flags_nxt[0] | in_overflow;
`else
      flags_nxt[0]   = in_overflow;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      flags  <= 4'b0000;
    end else begin
      flags <= flags_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
